debounce_sync: RTL

Conditions a raw, asynchronous pushbutton/switch pin into a clean, glitch-free logic level for the downstream combinational lab stages, such as the inverter stage. The block synchronises the pin into the clock domain. It accepts a level change only after the change has held for a programmable number of consecutive cycles. It also emits single-cycle rise/fall pulses and keeps a wrapping press counter.

---
 rtl/debounce_sync.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Turns a raw, possibly bouncing pushbutton/switch pin into a clean level for
// the downstream gate stages. The pin is first brought into the clk domain
// through a SYNC_STAGES-deep flop chain. A four-state FSM then accepts a new
// level only after STABLE_CYCLES consecutive synchronised samples of that
// level. Each accepted edge produces a one-cycle rise or fall pulse, and every
// accepted press advances a wrapping press counter.
//
// Parameters
//   SYNC_STAGES   synchroniser depth on btn_in (>= 2)
//   STABLE_CYCLES consecutive samples needed to accept a level (2 .. 2^CNT_W-1)
//   CNT_W         stability counter width
//   PCNT_W        press_count width
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   btn_in       raw asynchronous pin
//   btn_clean    debounced level
//   rise_pulse   one-cycle pulse when btn_clean goes 0->1
//   fall_pulse   one-cycle pulse when btn_clean goes 1->0
//   busy         high while a candidate change is being qualified
//   press_count  number of accepted rising edges, wraps silently
// -----------------------------------------------------------------------------
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16,
    parameter int PCNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_in,
    output logic              btn_clean,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic              busy,
    output logic [PCNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Terminal count: reaching it while the sample still agrees means this
    // edge takes the STABLE_CYCLES-th consecutive sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   clean_next;
    logic                   rise_next;
    logic                   fall_next;
    logic [PCNT_W-1:0]      pcnt_next;

    // ---- stage: synchroniser chain --------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // ---- stage: qualification FSM, next-state logic -----------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = btn_clean;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        pcnt_next  = press_count;

        case (state)
            IDLE_LOW: begin
                if (btn_s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next   = '0;
                end
            end

            WAIT_HIGH: begin
                if (!btn_s) begin
                    // Bounce: drop the candidate, output untouched.
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    clean_next = 1'b1;
                    rise_next  = 1'b1;
                    pcnt_next  = press_count + PCNT_W'(1);
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end

            IDLE_HIGH: begin
                if (!btn_s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next   = '0;
                end
            end

            WAIT_LOW: begin
                if (btn_s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    clean_next = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // ---- stage: FSM state and registered outputs --------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE_LOW;
            cnt         <= '0;
            btn_clean   <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            btn_clean   <= clean_next;
            rise_pulse  <= rise_next;
            fall_pulse  <= fall_next;
            press_count <= pcnt_next;
        end
    end

    // Pure decode of the state register, so no path from btn_in.
    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule
